// File: rtl/demux1_2_tdm_deser_pkg.sv
// Shared types and helpers for the 1:2 TDM deserializer: FSM state encoding
// and the frame bit-counter width.
package demux1_2_tdm_deser_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  // Width of a counter that reaches 2*w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (2 * w > 1) ? $clog2(2 * w) : 1;
  endfunction

endpackage

// File: rtl/and_two_input_gate.sv
// Two-input AND used as a structural building block.
module and_two_input_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/demux1_2_1bit.sv
// Combinational 1:2 demux: routes `in` to out0 when selec=0, to out1 when selec=1.
module demux1_2_1bit (
  input  logic in,
  input  logic selec,
  output logic out0,
  output logic out1
);

  logic selec_n;

  inversor_as_not_gate u_inv (
    .a (selec),
    .y (selec_n)
  );

  and_two_input_gate u_and0 (
    .a (in),
    .b (selec_n),
    .y (out0)
  );

  and_two_input_gate u_and1 (
    .a (in),
    .b (selec),
    .y (out1)
  );

endmodule

// File: rtl/inversor_as_not_gate.sv
// Single-input inverter used as a structural building block.
module inversor_as_not_gate (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/demux1_2_tdm_deser.sv
// Receive side of a 1-bit two-channel TDM line: splits the interleaved serial
// stream into two W-bit words, aligned by a sync pulse on each frame's first bit.
module demux1_2_tdm_deser
  import demux1_2_tdm_deser_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         in_demux_1bit,
  input  logic         valid_in,
  input  logic         sync_in,
  output logic [W-1:0] out0_word,
  output logic [W-1:0] out1_word,
  output logic         word_valid,
  output logic         frame_err,
  output logic         selec_1bit
);

  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sh0, sh1, sh0_nxt, sh1_nxt;
  logic          en0, en1;
  logic          start, take, done, err;

  // Per-channel shift enables: the valid strobe steered by the current select.
  demux1_2_1bit u_demux (
    .in    (valid_in),
    .selec (selec_1bit),
    .out0  (en0),
    .out1  (en1)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: each combinational output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (valid_in && sync_in) state_nxt = ST_RECV;
      ST_RECV: if (valid_in && !sync_in && cnt == LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A sync bit always (re)starts a frame; in RECV it also discards the partial frame.
  always_comb begin
    start = valid_in && sync_in;
    err   = (state == ST_RECV) && valid_in && sync_in && (cnt != '0);
    take  = (state == ST_RECV) && valid_in && !sync_in;
    done  = take && (cnt == LAST);
  end

  always_comb begin
    sh0_nxt = en0 ? W'({sh0, in_demux_1bit}) : sh0;
    sh1_nxt = en1 ? W'({sh1, in_demux_1bit}) : sh1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt        <= '0;
      sh0        <= '0;
      sh1        <= '0;
      selec_1bit <= 1'b0;
      out0_word  <= '0;
      out1_word  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= done;
      frame_err  <= err;
      if (start) begin
        sh0        <= W'(in_demux_1bit);
        sh1        <= '0;
        cnt        <= CW'(1);
        selec_1bit <= 1'b1;
      end else if (take) begin
        sh0 <= sh0_nxt;
        sh1 <= sh1_nxt;
        if (done) begin
          // Last bit lands in the output words directly so they appear one clock later.
          out0_word  <= sh0_nxt;
          out1_word  <= sh1_nxt;
          cnt        <= '0;
          selec_1bit <= 1'b0;
        end else begin
          cnt        <= cnt + CW'(1);
          selec_1bit <= ~selec_1bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux1_2_tdm_deser.sv
// Self-checking bench for demux1_2_tdm_deser: directed frames plus random
// traffic compared cycle by cycle against a bit-queue reference model.
module tb_demux1_2_tdm_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         in_demux_1bit = 1'b0;
  logic         valid_in = 1'b0;
  logic         sync_in = 1'b0;
  logic [W-1:0] out0_word, out1_word;
  logic         word_valid, frame_err, selec_1bit;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bits of the frame in progress, oldest first.
  bit           q[$];
  logic [W-1:0] exp0 = '0, exp1 = '0;
  logic         exp_wv = 1'b0, exp_fe = 1'b0, exp_sel = 1'b0;

  always #5 clk = ~clk;

  demux1_2_tdm_deser #(.W(W)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .in_demux_1bit (in_demux_1bit),
    .valid_in      (valid_in),
    .sync_in       (sync_in),
    .out0_word     (out0_word),
    .out1_word     (out1_word),
    .word_valid    (word_valid),
    .frame_err     (frame_err),
    .selec_1bit    (selec_1bit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out0"},  32'(out0_word),  32'(exp0));
    check({tag, ".out1"},  32'(out1_word),  32'(exp1));
    check({tag, ".wv"},    32'(word_valid), 32'(exp_wv));
    check({tag, ".ferr"},  32'(frame_err),  32'(exp_fe));
    check({tag, ".selec"}, 32'(selec_1bit), 32'(exp_sel));
  endtask

  task automatic model_reset();
    q.delete();
    exp0 = '0; exp1 = '0; exp_wv = 1'b0; exp_fe = 1'b0; exp_sel = 1'b0;
  endtask

  // One accepted edge: frame = 2*W bits, even positions are ch0, odd are ch1.
  task automatic model_step(input bit b, input bit v, input bit s);
    logic [W-1:0] a, c;
    exp_wv = 1'b0;
    exp_fe = 1'b0;
    if (v) begin
      if (s) begin
        if (q.size() != 0) exp_fe = 1'b1;
        q.delete();
        q.push_back(b);
      end else if (q.size() != 0) begin
        q.push_back(b);
        if (q.size() == 2 * W) begin
          a = '0; c = '0;
          for (int i = 0; i < W; i++) begin
            a = (a << 1) | W'(q[2 * i]);
            c = (c << 1) | W'(q[2 * i + 1]);
          end
          exp0 = a; exp1 = c; exp_wv = 1'b1;
          q.delete();
        end
      end
    end
    exp_sel = logic'(q.size() % 2);
  endtask

  task automatic cyc(input string tag, input bit b, input bit v, input bit s);
    in_demux_1bit = b;
    valid_in      = v;
    sync_in       = s;
    @(posedge clk);
    model_step(b, v, s);
    #1;
    check_all(tag);
  endtask

  task automatic send_frame(input string tag, input logic [W-1:0] c0, input logic [W-1:0] c1);
    for (int i = 0; i < W; i++) begin
      cyc(tag, c0[W-1-i], 1'b1, i == 0);
      cyc(tag, c1[W-1-i], 1'b1, 1'b0);
    end
  endtask

  // Async reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    valid_in = 1'b0;
    sync_in  = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    bit frame1[8];
    int k;
    frame1 = '{1, 0, 0, 1, 1, 1, 0, 0};

    // Reset state
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset_L = 1'b1;
    cyc("idle", 1'b0, 1'b0, 1'b0);

    // Single frame, valid held high
    for (int i = 0; i < 8; i++) cyc("single", frame1[i], 1'b1, i == 0);
    check("single.lit_out0", 32'(out0_word), 32'h0000_000A);
    check("single.lit_out1", 32'(out1_word), 32'h0000_0006);
    check("single.lit_wv",   32'(word_valid), 32'h1);
    cyc("single_after", 1'b0, 1'b0, 1'b0);
    check("single.wv_drop", 32'(word_valid), 32'h0);

    // Same frame with stalls after bits 2 and 5; stall cycles carry junk data
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cyc("stall", frame1[i], 1'b1, i == 0);
      if (i == 1 || i == 4) begin
        cyc("stall", 1'b1, 1'b0, 1'b1);
        k++;
      end
    end
    check("stall.lit_out0", 32'(out0_word), 32'h0000_000A);
    check("stall.lit_out1", 32'(out1_word), 32'h0000_0006);
    check("stall.count", 32'(k), 32'd2);

    // Back-to-back frames, no gap
    send_frame("b2b_a", 4'h5, 4'hA);
    send_frame("b2b_b", 4'hF, 4'h0);
    check("b2b.lit_out0", 32'(out0_word), 32'h0000_000F);
    check("b2b.lit_out1", 32'(out1_word), 32'h0000_0000);

    // Mid-frame sync at bit 5: error, outputs hold, new frame decodes
    for (int i = 0; i < 4; i++) cyc("midsync", 1'(i), 1'b1, i == 0);
    send_frame("midsync_new", 4'h9, 4'h6);
    check("midsync.lit_out0", 32'(out0_word), 32'h0000_0009);
    check("midsync.lit_out1", 32'(out1_word), 32'h0000_0006);

    // No sync from IDLE: 16 valid bits dropped
    for (int i = 0; i < 16; i++) cyc("nosync", 1'($urandom), 1'b1, 1'b0);
    check("nosync.lit_out0", 32'(out0_word), 32'h0000_0009);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) cyc("prereset", 1'b1, 1'b1, i == 0);
    async_reset("midreset");
    send_frame("postreset", 4'h3, 4'hC);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc("rand", 1'($urandom), ($urandom_range(3) != 0), ($urandom_range(9) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
